// File: rtl/int_ctrl_if.sv
// CPU-side handshake between the interrupt controller (master) and the control unit (slave):
// request/vector/id from the controller, calli acknowledge and reti from the CPU.
interface int_ctrl_if;
  logic       int_req;
  logic [7:0] int_vec;
  logic [2:0] int_id;
  logic       ack;
  logic       reti;

  modport master (output int_req, int_vec, int_id, input  ack, reti);
  modport slave  (input  int_req, int_vec, int_id, output ack, reti);
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: priority interrupt controller (edge-latched pending, mask, calli/reti in-service tracking).
// Optional macro NESTING_EN lets a higher-priority line preempt a line already in service.
module int_ctrl #(
  parameter int unsigned N          = 8,
  parameter logic [7:0]  VEC_BASE   = 8'h10,
  parameter int unsigned VEC_STRIDE = 4,
  parameter logic [7:0]  MASK_RST   = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  int_ctrl_if.master    cpu,
  input  logic [N-1:0]  int_e,
  input  logic          mask_we,
  input  logic [N-1:0]  mask_wdata,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t       state;
  logic [N-1:0] sync_p0, sync_p1, sync_p2, mask;
  logic         req_q;
  logic [7:0]   vec_q;
  logic [2:0]   id_q;

  logic [N-1:0] rise, eligible, ack_bit, isr_after_reti, isr_nx, pend_nx;
  logic [2:0]   win;
  logic         ack_take, reti_take;

  function automatic logic [2:0] lowest_idx(input logic [N-1:0] v);
    logic [2:0] idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [2:0] id);
    return N'(1) << id;
  endfunction

  function automatic logic [7:0] vec_of(input logic [2:0] id);
    logic [31:0] v;
    v = 32'(VEC_BASE) + 32'(id) * VEC_STRIDE;
    return v[7:0];
  endfunction

  assign cpu.int_req = req_q;
  assign cpu.int_vec = vec_q;
  assign cpu.int_id  = id_q;

  // reti clears the lowest in-service bit before a same-cycle ack sets the new one;
  // a fresh edge on the acked line survives the ack's pending clear.
  always_comb begin
    rise           = sync_p1 & ~sync_p2;
    eligible       = pending & mask;
    win            = lowest_idx(eligible);
    ack_take       = (state == REQ) && cpu.ack;
    reti_take      = cpu.reti && (in_service != '0);
    ack_bit        = ack_take ? onehot(id_q) : '0;
    isr_after_reti = reti_take ? (in_service & (in_service - N'(1))) : in_service;
    isr_nx         = isr_after_reti | ack_bit;
    pend_nx        = (pending & ~ack_bit) | rise;
  end

  // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
      mask    <= MASK_RST[N-1:0];
    end else begin
      sync_p0 <= int_e;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= '0;
      in_service <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
      id_q       <= '0;
    end else begin
      pending    <= pend_nx;
      in_service <= isr_nx;
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            state <= REQ;
            req_q <= 1'b1;
            id_q  <= win;
            vec_q <= vec_of(win);
          end
        end
        REQ: begin
          if (cpu.ack) begin
            state <= SERVICE;
            req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (isr_nx == '0) begin
            state <= IDLE;
          end
`ifdef NESTING_EN
          else if ((eligible != '0) && (win < lowest_idx(isr_nx))) begin
            state <= REQ;
            req_q <= 1'b1;
            id_q  <= win;
            vec_q <= vec_of(win);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle-by-cycle vector table plus hand sequences for
// nesting, frozen request, same-cycle ack/reti and asynchronous reset.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] int_e;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] pending;
  logic [7:0] in_service;

  int tests  = 0;
  int failed = 0;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .int_e      (int_e),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] e;
    logic       ack;
    logic       reti;
    logic       we;
    logic [7:0] wd;
    logic       req;
    logic [7:0] vec;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] isr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] e, input logic ack, input logic reti,
                              input logic we, input logic [7:0] wd, input logic req,
                              input logic [7:0] vec, input logic [2:0] id,
                              input logic [7:0] pend, input logic [7:0] isr);
    vec_t r;
    r.e = e; r.ack = ack; r.reti = reti; r.we = we; r.wd = wd;
    r.req = req; r.vec = vec; r.id = id; r.pend = pend; r.isr = isr;
    return r;
  endfunction

  // Apply inputs for one clock, then sample 1 ns after the rising edge.
  task automatic drive(input logic [7:0] e, input logic a, input logic r,
                       input logic we, input logic [7:0] wd);
    int_e = e; bus.ack = a; bus.reti = r; mask_we = we; mask_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check(input string name, input logic xr, input logic [7:0] xv,
                       input logic [2:0] xi, input logic [7:0] xp, input logic [7:0] xs);
    tests++;
    if (bus.int_req !== xr || pending !== xp || in_service !== xs ||
        (xr && (bus.int_vec !== xv || bus.int_id !== xi))) begin
      failed++;
      $display("FAIL %s: got req=%0b vec=%h id=%0d pend=%h isr=%h, expected req=%0b vec=%h id=%0d pend=%h isr=%h",
               name, bus.int_req, bus.int_vec, bus.int_id, pending, in_service,
               xr, xv, xi, xp, xs);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    int_e = '0; bus.ack = 1'b0; bus.reti = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);
    reset = 1'b1;
    idle();
    check("reset_release", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);

    // single line 3: pending on 3rd edge, request one edge later, ack, reti
    tbl.push_back(mk(8'h08,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h08,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h1C,3'd3,8'h08,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h08));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    // lines 5 and 2 together: 2 first, then 5
    tbl.push_back(mk(8'h24,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h24,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h18,3'd2,8'h24,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h20,8'h04));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h20,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h24,3'd5,8'h20,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h20));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    // mask off line 2, edge stays pending, unmask releases the request
    tbl.push_back(mk(8'h00,0,0,1,8'hFB, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h04,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h04,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h04,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h04,8'h00));
    tbl.push_back(mk(8'h00,0,0,1,8'hFF, 0,8'h00,3'd0,8'h04,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h18,3'd2,8'h04,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h04));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    // ack outside REQ and reti with nothing in service are ignored
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    // new edge on line 3 lands on the ack edge: second request kept
    tbl.push_back(mk(8'h08,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 0,8'h00,3'd0,8'h08,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h1C,3'd3,8'h08,8'h00));
    tbl.push_back(mk(8'h08,0,0,0,8'h00, 1,8'h1C,3'd3,8'h08,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h1C,3'd3,8'h08,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h08,8'h08));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h08,8'h00));
    tbl.push_back(mk(8'h00,0,0,0,8'h00, 1,8'h1C,3'd3,8'h08,8'h00));
    tbl.push_back(mk(8'h00,1,0,0,8'h00, 0,8'h00,3'd0,8'h00,8'h08));
    tbl.push_back(mk(8'h00,0,1,0,8'h00, 0,8'h00,3'd0,8'h00,8'h00));

    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].ack, tbl[i].reti, tbl[i].we, tbl[i].wd);
      check($sformatf("row%0d", i), tbl[i].req, tbl[i].vec, tbl[i].id, tbl[i].pend, tbl[i].isr);
    end

    // line 4 in service, then line 1 arrives
    drive(8'h10, 1'b0, 1'b0, 1'b0, 8'h00); idle(); idle();
    check("l4_pending", 1'b0, 8'h00, 3'd0, 8'h10, 8'h00);
    idle();
    check("l4_req", 1'b1, 8'h20, 3'd4, 8'h10, 8'h00);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("l4_ack", 1'b0, 8'h00, 3'd0, 8'h00, 8'h10);
    drive(8'h02, 1'b0, 1'b0, 1'b0, 8'h00); idle(); idle();
    check("l1_pending", 1'b0, 8'h00, 3'd0, 8'h02, 8'h10);
    idle();
`ifdef NESTING_EN
    check("nest_req", 1'b1, 8'h14, 3'd1, 8'h02, 8'h10);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("nest_ack", 1'b0, 8'h00, 3'd0, 8'h00, 8'h12);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    check("nest_reti1", 1'b0, 8'h00, 3'd0, 8'h00, 8'h10);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    check("nest_reti2", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);
`else
    check("no_nest_wait", 1'b0, 8'h00, 3'd0, 8'h02, 8'h10);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    check("l4_reti", 1'b0, 8'h00, 3'd0, 8'h02, 8'h00);
    idle();
    check("l1_req", 1'b1, 8'h14, 3'd1, 8'h02, 8'h00);
    drive(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("l1_ack", 1'b0, 8'h00, 3'd0, 8'h00, 8'h02);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    check("l1_reti", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);
`endif

    // REQ on line 6 stays frozen while line 0 becomes pending; ack+reti together
    drive(8'h40, 1'b0, 1'b0, 1'b0, 8'h00); idle(); idle(); idle();
    check("l6_req", 1'b1, 8'h28, 3'd6, 8'h40, 8'h00);
    drive(8'h01, 1'b0, 1'b0, 1'b0, 8'h00); idle(); idle();
    check("l6_frozen", 1'b1, 8'h28, 3'd6, 8'h41, 8'h00);
    drive(8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    check("ack_reti_same", 1'b0, 8'h00, 3'd0, 8'h01, 8'h40);
    drive(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    check("l6_reti", 1'b0, 8'h00, 3'd0, 8'h01, 8'h00);
    idle();
    check("l0_req", 1'b1, 8'h10, 3'd0, 8'h01, 8'h00);
    drive(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    check("masked_frozen", 1'b1, 8'h10, 3'd0, 8'h01, 8'h00);

    // asynchronous reset in the middle of REQ, mask returns to all-enabled
    reset = 1'b0;
    #1;
    check("async_reset", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);
    idle();
    reset = 1'b1;
    idle();
    check("after_reset", 1'b0, 8'h00, 3'd0, 8'h00, 8'h00);
    drive(8'h01, 1'b0, 1'b0, 1'b0, 8'h00); idle(); idle(); idle();
    check("mask_reset_val", 1'b1, 8'h10, 3'd0, 8'h01, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
